fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage of the pipelined ARM core. It holds the program counter and drives the word-indexed, combinational-read instruction memory. It captures each returned instruction with its PC+4 into the IF/ID pipeline register for the decode stage. It honours hazard-unit freezes and execute-stage branch redirects, and inserts NOP bubbles on flush.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, byte address loaded into PC on reset.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-low reset (asserted at 0).
- freeze  input  1  hazard stall; hold PC and IF/ID contents.
- branch_taken  input  1  redirect request from execute stage.
- branch_addr  input  32  byte-address branch target.
- imem_addr  output  32  word index to instruction memory, {2'b00, pc[31:2]}.
- imem_instr  input  32  instruction returned combinationally for imem_addr.
- if_id_pc  output  32  PC+4 of the instruction held in IF/ID.
- if_id_instr  output  32  instruction held in IF/ID.
- if_id_valid  output  1  IF/ID holds a real instruction (0 = bubble).

## Operation
- PC register, 32 bits, always word-aligned; pc[1:0] is always 00.
- Normal cycle (no freeze, no branch):
  - pc <= pc + 4, wrapping modulo 2^32 (32'hFFFF_FFFC -> 0).
  - IF/ID <= {pc + 4, imem_instr, valid=1}.
- freeze=1, branch_taken=0: pc, if_id_pc, if_id_instr and if_id_valid all hold.
- branch_taken=1, regardless of freeze:
  - pc <= {branch_addr[31:2], 2'b00}; branch_addr[1:0] is ignored.
  - IF/ID flushed: if_id_instr <= NOP (32'hE000_0000), if_id_pc <= 0, if_id_valid <= 0.
  - Branch has priority over freeze.
- Consecutive branch_taken cycles: each reloads PC and re-flushes; the last target wins.
- imem_addr is purely combinational from pc; no registered path through memory.
- Reset (async, any time, including mid-freeze or mid-branch):
  - pc = RESET_PC; if_id_pc = 0; if_id_instr = NOP; if_id_valid = 0.
  - imem_addr = RESET_PC >> 2.
- Reset release: the first fetch occurs at the first rising edge with rst=1.

## Timing
- Fetch latency: 1 cycle. The instruction at pc in cycle t appears on if_id_instr after edge t, with if_id_pc = pc+4.
- Branch penalty seen at this stage:
  - Asserted in cycle t: edge t loads target and flushes.
  - Cycle t+1: imem_addr = target>>2.
  - After edge t+1: target instruction is in IF/ID with valid=1.
  - Instructions fetched after the branch but before the redirect are squashed by the flush here; deeper flushes are the execute/decode stages' responsibility.
- Freeze is level-sensitive; one held cycle per freeze cycle, no internal counting.
- All outputs except imem_addr are registered.

## Structure
- Shared package arm_pkg holds:
  - NOP_INSTR = 32'hE000_0000.
  - WORD_W = 32.
  - PC_INC = 4.
  - RESET_PC default.
- Decode and later stages use the same NOP_INSTR.
- Sub-module if_id_reg: the IF/ID register with load, hold (freeze) and flush (branch) controls, flush dominant.
- fetch_stage owns the PC register, the incrementer, the target mux and the imem_addr formation.

## Test plan
- Reset: hold rst=0 with random inputs -> pc=0, imem_addr=0, if_id_instr=32'hE000_0000, if_id_valid=0. Release -> edges 1, 2, 3 give if_id_pc=4, 8, 12 with imem words 0, 1, 2 captured.
- Freeze: freeze=1 for 3 cycles at pc=16 -> imem_addr stays 4, IF/ID unchanged. Release -> next capture is the word at index 4 with if_id_pc=20.
- Branch: branch_taken=1, branch_addr=32'h0000_0093 -> pc=32'h90, IF/ID flushed with valid=0. Next edge captures word 36 with if_id_pc=32'h94.
- Branch during freeze: freeze=1 and branch_taken=1, branch_addr=0x40 -> PC becomes 0x40 and IF/ID is flushed; freeze is ignored that cycle.
- Wrap and async reset: RESET_PC=32'hFFFF_FFFC -> after one edge pc=0 and if_id_pc=0. Assert rst mid-cycle -> all outputs reset immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/arm_pkg.sv
// Shared ARM core constants and IF/ID pipeline types used by fetch, decode and later stages.
package arm_pkg;

  localparam int unsigned WORD_W = 32;
  localparam logic [WORD_W-1:0] NOP_INSTR = 32'hE000_0000;
  localparam logic [WORD_W-1:0] PC_INC = 32'd4;
  localparam logic [WORD_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] instr;
    logic              valid;
  } if_id_t;

  localparam if_id_t IF_ID_BUBBLE = '{pc: '0, instr: NOP_INSTR, valid: 1'b0};

  // Instruction memory is word-indexed; the byte offset bits are dropped.
  function automatic logic [WORD_W-1:0] word_index(input logic [WORD_W-1:0] byte_addr);
    return byte_addr >> 2;
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: load on advance, hold on freeze, flush to a NOP bubble (flush dominant).
module if_id_reg
  import arm_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              flush,
  input  logic [WORD_W-1:0] pc_in,
  input  logic [WORD_W-1:0] instr_in,
  output logic [WORD_W-1:0] pc_out,
  output logic [WORD_W-1:0] instr_out,
  output logic              valid_out
);

  if_id_t entry_q;
  if_id_t entry_d;

  always_comb begin
    entry_d = entry_q;
    if (flush) begin
      entry_d = IF_ID_BUBBLE;
    end else if (load) begin
      entry_d = '{pc: pc_in, instr: instr_in, valid: 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      entry_q <= IF_ID_BUBBLE;
    end else begin
      entry_q <= entry_d;
    end
  end

  assign pc_out    = entry_q.pc;
  assign instr_out = entry_q.instr;
  assign valid_out = entry_q.valid;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, incrementer, branch target mux and imem word addressing.
module fetch_stage
  import arm_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        branch_taken,
  input  logic [31:0] branch_addr,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_instr,
  output logic        if_id_valid
);

  logic [WORD_W-1:0] pc_q;
  logic [WORD_W-1:0] pc_d;
  logic [WORD_W-1:0] pc_plus4;
  logic [WORD_W-1:0] branch_target;

  always_comb begin
    pc_plus4      = pc_q + PC_INC;
    branch_target = branch_addr & ~32'h3;
    pc_d          = pc_q;
    // Redirect wins over a hazard freeze.
    if (branch_taken) begin
      pc_d = branch_target;
    end else if (!freeze) begin
      pc_d = pc_plus4;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q <= RESET_PC & ~32'h3;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign imem_addr = word_index(pc_q);

  if_id_reg u_if_id_reg (
    .clk       (clk),
    .rst       (rst),
    .load      (!freeze),
    .flush     (branch_taken),
    .pc_in     (pc_plus4),
    .instr_in  (imem_instr),
    .pc_out    (if_id_pc),
    .instr_out (if_id_instr),
    .valid_out (if_id_valid)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized freeze/branch/reset traffic.
module tb_fetch_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [31:0] NOP = 32'hE000_0000;

  logic        rst;
  logic        freeze;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_instr;
  logic        if_id_valid;

  logic        w_freeze;
  logic        w_branch_taken;
  logic [31:0] w_branch_addr;
  logic [31:0] w_imem_addr;
  logic [31:0] w_imem_instr;
  logic [31:0] w_if_id_pc;
  logic [31:0] w_if_id_instr;
  logic        w_if_id_valid;

  function automatic logic [31:0] mem_word(input logic [31:0] idx);
    return (idx * 32'h9E37_79B9) ^ 32'h5A5A_1234;
  endfunction

  assign imem_instr   = mem_word(imem_addr);
  assign w_imem_instr = mem_word(w_imem_addr);

  fetch_stage dut (
    .clk          (clk),
    .rst          (rst),
    .freeze       (freeze),
    .branch_taken (branch_taken),
    .branch_addr  (branch_addr),
    .imem_addr    (imem_addr),
    .imem_instr   (imem_instr),
    .if_id_pc     (if_id_pc),
    .if_id_instr  (if_id_instr),
    .if_id_valid  (if_id_valid)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk          (clk),
    .rst          (rst),
    .freeze       (w_freeze),
    .branch_taken (w_branch_taken),
    .branch_addr  (w_branch_addr),
    .imem_addr    (w_imem_addr),
    .imem_instr   (w_imem_instr),
    .if_id_pc     (w_if_id_pc),
    .if_id_instr  (w_if_id_instr),
    .if_id_valid  (w_if_id_valid)
  );

  int unsigned checks = 0;
  int unsigned failures = 0;

  // Reference model: byte PC and the IF/ID contents the spec says should be held.
  logic [31:0] m_pc;
  logic [31:0] m_ipc;
  logic [31:0] m_instr;
  logic        m_valid;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".imem_addr"}, imem_addr, m_pc / 4);
    check({tag, ".pc"}, if_id_pc, m_ipc);
    check({tag, ".instr"}, if_id_instr, m_instr);
    check({tag, ".valid"}, {31'b0, if_id_valid}, {31'b0, m_valid});
  endtask

  task automatic model_reset();
    m_pc    = 32'h0;
    m_ipc   = 32'h0;
    m_instr = NOP;
    m_valid = 1'b0;
  endtask

  task automatic step(input logic f, input logic b, input logic [31:0] a, input string tag);
    freeze       = f;
    branch_taken = b;
    branch_addr  = a;
    @(posedge clk);
    if (b) begin
      m_pc    = {a[31:2], 2'b00};
      m_ipc   = 32'h0;
      m_instr = NOP;
      m_valid = 1'b0;
    end else if (!f) begin
      m_ipc   = m_pc + 32'd4;
      m_instr = mem_word(m_pc / 4);
      m_valid = 1'b1;
      m_pc    = m_pc + 32'd4;
    end
    #1;
    check_all(tag);
  endtask

  // Called #1 after a rising edge: pulses reset between edges and checks it acts at once.
  task automatic async_reset(input string tag);
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check_all({tag, ".immediate"});
    freeze       = 1'($urandom);
    branch_taken = 1'($urandom);
    branch_addr  = $urandom;
    #1;
    check_all({tag, ".held"});
    #1;
    rst = 1'b1;
  endtask

  initial begin
    rst            = 1'b0;
    freeze         = 1'b0;
    branch_taken   = 1'b0;
    branch_addr    = '0;
    w_freeze       = 1'b0;
    w_branch_taken = 1'b0;
    w_branch_addr  = '0;
    model_reset();

    for (int i = 0; i < 4; i++) begin
      freeze       = 1'($urandom);
      branch_taken = 1'($urandom);
      branch_addr  = $urandom;
      @(negedge clk);
      check_all("in_reset");
    end
    check("wrap.reset_imem_addr", w_imem_addr, 32'h3FFF_FFFF);
    check("wrap.reset_valid", {31'b0, w_if_id_valid}, 32'h0);

    freeze       = 1'b0;
    branch_taken = 1'b0;
    rst          = 1'b1;

    step(1'b0, 1'b0, '0, "fetch1");
    check("fetch1.pc_const", if_id_pc, 32'd4);
    check("fetch1.word0", if_id_instr, mem_word(32'd0));
    check("wrap.pc", w_if_id_pc, 32'h0);
    check("wrap.imem_addr", w_imem_addr, 32'h0);
    check("wrap.instr", w_if_id_instr, mem_word(32'h3FFF_FFFF));
    check("wrap.valid", {31'b0, w_if_id_valid}, 32'h1);
    step(1'b0, 1'b0, '0, "fetch2");
    check("fetch2.pc_const", if_id_pc, 32'd8);
    step(1'b0, 1'b0, '0, "fetch3");
    check("fetch3.pc_const", if_id_pc, 32'd12);
    check("fetch3.word2", if_id_instr, mem_word(32'd2));
    step(1'b0, 1'b0, '0, "fetch4");

    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, '0, "freeze");
      check("freeze.imem_addr_const", imem_addr, 32'd4);
    end
    step(1'b0, 1'b0, '0, "unfreeze");
    check("unfreeze.pc_const", if_id_pc, 32'd20);
    check("unfreeze.word4", if_id_instr, mem_word(32'd4));

    step(1'b0, 1'b1, 32'h0000_0093, "branch");
    check("branch.imem_addr_const", imem_addr, 32'd36);
    check("branch.instr_nop", if_id_instr, NOP);
    step(1'b0, 1'b0, '0, "after_branch");
    check("after_branch.pc_const", if_id_pc, 32'h94);
    check("after_branch.word36", if_id_instr, mem_word(32'd36));

    step(1'b1, 1'b1, 32'h0000_0040, "branch_freeze");
    check("branch_freeze.imem_addr_const", imem_addr, 32'h10);
    check("branch_freeze.valid", {31'b0, if_id_valid}, 32'h0);
    step(1'b1, 1'b1, 32'h0000_0101, "branch_again");
    check("branch_again.imem_addr_const", imem_addr, 32'h40);

    async_reset("async");
    check("async.wrap_imem_addr", w_imem_addr, 32'h3FFF_FFFF);

    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0, $urandom, "rand");
      if ($urandom_range(0, 39) == 0) begin
        async_reset("rand_reset");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL timeout got=running exp=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
